// File: rtl/fifo_ctrl_pkg.sv
// fifo_ctrl_pkg
// Shared definitions for the SyncFIFO write-side control path: the write
// arbiter FSM state encoding and the default FIFO geometry, so that the
// arbiter and the FIFO agree on data width and depth.
// No ports (package).
package fifo_ctrl_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    localparam int BITWIDTH_DEF  = 5;
    localparam int DEPTH_DEF     = 4;
    localparam int NREQ_DEF      = 4;
    localparam int MAX_BURST_DEF = 4;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick
// Purely combinational rotating-priority selector. Picks the first asserted
// request at or after index (i_lastIdx+1) mod NREQ, wrapping around.
// Ports:
//   i_req     [NREQ-1:0]  request vector
//   i_lastIdx [IW-1:0]    index of the previous owner
//   o_oneHot  [NREQ-1:0]  one-hot pick (all zero when no request)
//   o_idx     [IW-1:0]    index of the pick (0 when no request)
module rr_pick
    import fifo_ctrl_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_lastIdx,
    output logic [NREQ-1:0] o_oneHot,
    output logic [IW-1:0]   o_idx
);

    int w_j;

    // Scan from the farthest offset down to the nearest so that the nearest
    // asserted request (highest priority) is the last one written.
    always_comb begin
        o_oneHot = '0;
        o_idx    = '0;
        w_j      = 0;
        for (int k = NREQ; k >= 1; k--) begin
            w_j = (int'(i_lastIdx) + k) % NREQ;
            if (i_req[w_j]) begin
                o_oneHot      = '0;
                o_oneHot[w_j] = 1'b1;
                o_idx         = IW'(w_j);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Shares one SyncFIFO write port between NREQ producers. A producer is
// granted a tenure of up to MAX_BURST writes; the tenure ends early when the
// producer drops its request. A full FIFO stalls the tenure indefinitely.
// Every tenure is followed by one IDLE cycle in which the next owner is
// picked with rotating priority.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   req  [NREQ-1:0]    per-producer write request
//   dIn  [NREQ*BW-1:0] producer data, slice i = producer i
//   fifoFull           SyncFIFO full flag
//   gnt  [NREQ-1:0]    registered one-hot grant
//   gntIdx             registered granted index
//   fifoWEn, fifoDIn   SyncFIFO write port
//   busy               high while a tenure is open
module fifo_wr_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int NREQ      = NREQ_DEF,
    parameter int BITWIDTH  = BITWIDTH_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF,
    parameter int IW        = (NREQ > 1) ? $clog2(NREQ) : 1,
    parameter int CW        = $clog2(MAX_BURST + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*BITWIDTH-1:0] dIn,
    input  logic                     fifoFull,
    output logic [NREQ-1:0]          gnt,
    output logic [IW-1:0]            gntIdx,
    output logic                     fifoWEn,
    output logic [BITWIDTH-1:0]      fifoDIn,
    output logic                     busy
);

    arb_state_t          r_state, w_state_n;
    logic [NREQ-1:0]     r_gnt, w_gnt_n;
    logic [IW-1:0]       r_gntIdx, w_gntIdx_n;
    logic [CW-1:0]       r_cnt, w_cnt_n;
    logic [IW-1:0]       r_lastIdx, w_lastIdx_n;

    logic [NREQ-1:0]     w_pickOh;
    logic [IW-1:0]       w_pickIdx;
    logic                w_wr;
    logic [CW-1:0]       w_cntInc;
    logic [BITWIDTH-1:0] w_data;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .i_req     (req),
        .i_lastIdx (r_lastIdx),
        .o_oneHot  (w_pickOh),
        .o_idx     (w_pickIdx)
    );

    assign w_cntInc = r_cnt + CW'(1);

    always_comb begin
        w_state_n   = r_state;
        w_gnt_n     = r_gnt;
        w_gntIdx_n  = r_gntIdx;
        w_cnt_n     = r_cnt;
        w_lastIdx_n = r_lastIdx;
        w_wr        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_state_n  = ST_BURST;
                    w_gnt_n    = w_pickOh;
                    w_gntIdx_n = w_pickIdx;
                    w_cnt_n    = '0;
                end
            end
            ST_BURST: begin
                w_wr = req[r_gntIdx] & ~fifoFull;
                if (w_wr) begin
                    w_cnt_n = w_cntInc;
                end
                // A stalled write (full FIFO) keeps the tenure open; only a
                // dropped request or the final accepted write closes it.
                if (!req[r_gntIdx] || (w_wr && w_cntInc == CW'(MAX_BURST))) begin
                    w_state_n   = ST_IDLE;
                    w_gnt_n     = '0;
                    w_gntIdx_n  = '0;
                    w_lastIdx_n = r_gntIdx;
                end
            end
            default: begin
                w_state_n = ST_IDLE;
                w_gnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_gntIdx  <= '0;
            r_cnt     <= '0;
            r_lastIdx <= IW'(NREQ - 1);
        end else begin
            r_state   <= w_state_n;
            r_gnt     <= w_gnt_n;
            r_gntIdx  <= w_gntIdx_n;
            r_cnt     <= w_cnt_n;
            r_lastIdx <= w_lastIdx_n;
        end
    end

    always_comb begin
        w_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_gntIdx == IW'(i)) begin
                w_data = dIn[i*BITWIDTH +: BITWIDTH];
            end
        end
    end

    assign busy    = (r_state == ST_BURST);
    assign gnt     = r_gnt;
    assign gntIdx  = r_gntIdx;
    // Reset gates the write port immediately, before the registers clear.
    assign fifoWEn = w_wr & ~rst;
    assign fifoDIn = (busy && !rst) ? w_data : '0;

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of producers sharing one SyncFIFO write port.
REQ-002 SHALL have parameter BITWIDTH, default 5, data width (matches SyncFIFO BITWIDTH).
REQ-003 SHALL have parameter MAX_BURST, default 4, max writes per grant tenure (range 1..15).
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 req  input  NREQ  per-producer write request; bit i = producer i.
REQ-008 dIn  input  NREQ*BITWIDTH  producer data, slice i = dIn[i*BITWIDTH +: BITWIDTH].
REQ-009 fifoFull  input  1  full flag from SyncFIFO.
REQ-010 gnt  output  NREQ  registered one-hot grant (all-zero when idle).
REQ-011 gntIdx  output  clog2(NREQ)  registered index of the granted producer (0 when idle).
REQ-012 fifoWEn  output  1  write enable to SyncFIFO wEn.
REQ-013 fifoDIn  output  BITWIDTH  write data to SyncFIFO dIn.
REQ-014 busy  output  1  high while in state BURST.

Function
REQ-015 SHALL implement a two-state FSM: IDLE, BURST.
REQ-016 IDLE: if req != 0, SHALL select the first asserted req at or after index (lastIdx+1) mod NREQ, wrapping, register gnt/gntIdx, load burstCnt=0, and go to BURST; else remain IDLE.
REQ-017 Grant latency SHALL be one cycle: req sampled high at edge N -> gnt valid after edge N.
REQ-018 BURST: fifoWEn SHALL be combinational = req[gntIdx] & !fifoFull; fifoDIn SHALL = dIn slice gntIdx whenever busy, else 0.
REQ-019 Each cycle with fifoWEn=1 SHALL increment burstCnt (width clog2(MAX_BURST+1), no wrap).
REQ-020 fifoFull=1 SHALL stall: fifoWEn=0, burstCnt unchanged, grant held; no timeout.
REQ-021 Release SHALL occur at the edge where req[gntIdx]=0, or where a write brings burstCnt to MAX_BURST; on release: gnt<=0, lastIdx<=gntIdx, state<=IDLE.
REQ-022 One IDLE bubble cycle SHALL separate consecutive tenures; arbitration occurs in that cycle.
REQ-023 Requests from non-granted producers SHALL be ignored during BURST and never produce fifoWEn.
REQ-024 fifoWEn SHALL never be 1 while fifoFull=1 or busy=0.
REQ-025 Producer drop-and-reassert during BURST: drop releases per REQ-021; reassert competes normally.
REQ-026 With a single requester held high, it SHALL be re-granted after each bubble (MAX_BURST writes, 1 idle, repeat).

Reset
REQ-027 rst=1 at an edge SHALL force state=IDLE, gnt=0, gntIdx=0, burstCnt=0, lastIdx=NREQ-1 (so producer 0 wins first), overriding any in-progress burst.
REQ-028 While rst=1, fifoWEn SHALL be 0 and fifoDIn SHALL be 0 combinationally.
REQ-029 Reset mid-burst SHALL discard the tenure; no partial-burst state survives.

Structure
REQ-030 FSM state encoding (IDLE, BURST) SHALL live in shared package fifo_ctrl_pkg, alongside BITWIDTH/DEPTH defaults used by SyncFIFO.
REQ-031 The rotating priority pick SHALL be a sub-module rr_pick (inputs req, lastIdx; output one-hot and index), purely combinational.
REQ-032 Registers SHALL be in one clocked block, next-state logic in one combinational block with defaults assigned first (no latches).

Verification
REQ-033 rst 2 cycles, then req=4'b0001, dIn[0]=5'h0A, fifoFull=0 -> gnt=0001 one cycle later, 4 writes of 0x0A, release, bubble, re-grant.
REQ-034 req=4'b1111 held -> tenures ordered 0,1,2,3,0 each 4 writes with 1-cycle bubble; no fifoWEn in bubbles.
REQ-035 Producer 2 granted, fifoFull=1 for 3 cycles after write 2 -> fifoWEn=0 for those 3 cycles, burstCnt stays 2, then writes 3 and 4 complete.
REQ-036 Producer 1 granted, req[1] drops after 1 write -> release at that edge, lastIdx=1, next grant goes to lowest pending index above 1 (wrapping).
REQ-037 rst asserted mid-burst after write 2 -> next cycle gnt=0, busy=0, fifoWEn=0; after release of rst with req=4'b1000, producer 0 priority position restored (grant 3 since only 3 requests).
REQ-038 Bench SHALL connect a SyncFIFO (DEPTH=4) and scoreboard: FIFO read order equals per-producer data order, no write accepted while full.
